// File: rtl/key_debounce_scheduler_pkg.sv
// rtl/key_debounce_scheduler_pkg.sv - shared state encodings and default timing for the key debounce scheduler
package key_debounce_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TIME  = 2'd1,
        ST_CHECK = 2'd2,
        ST_EMIT  = 2'd3
    } sched_state_t;

    localparam int DEF_N_KEYS = 4;
    localparam int DEF_IDX_W  = 2;
    localparam int DEF_T1MS   = 49_999;
    localparam int DEF_DEB_MS = 20;

    // Width of a counter that must hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_scheduler_if.sv
// rtl/key_debounce_scheduler_if.sv - key event valid/ready port between scheduler and key-handling logic
interface key_debounce_scheduler_if #(
    parameter int IDX_W = 2
) ();
    logic             Evt_Valid;
    logic             Evt_Ready;
    logic [IDX_W-1:0] Evt_Key;
    logic             Evt_Press;

    modport master (
        output Evt_Valid,
        output Evt_Key,
        output Evt_Press,
        input  Evt_Ready
    );

    modport slave (
        input  Evt_Valid,
        input  Evt_Key,
        input  Evt_Press,
        output Evt_Ready
    );
endinterface

// File: rtl/key_debounce_scheduler_timer.sv
// rtl/key_debounce_scheduler_timer.sv - ms_window_timer: shared ms prescaler plus ms counter, pulses done at window end
module ms_window_timer
    import key_debounce_scheduler_pkg::*;
#(
    parameter int T1MS   = DEF_T1MS,
    parameter int DEB_MS = DEF_DEB_MS
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int PW = cnt_width(T1MS);
    localparam int MW = cnt_width(DEB_MS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(T1MS);
    localparam logic [MW-1:0] MS_LAST   = MW'(DEB_MS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [MW-1:0] ms_cnt_q, ms_cnt_d;

    // done fires on the prescaler wrap that would take ms_cnt to DEB_MS,
    // so the window is exactly DEB_MS*(T1MS+1) enabled clocks.
    always_comb begin
        presc_d  = presc_q;
        ms_cnt_d = ms_cnt_q;
        done     = 1'b0;
        if (clr) begin
            presc_d  = '0;
            ms_cnt_d = '0;
        end else if (en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (ms_cnt_q == MS_LAST) begin
                    done     = 1'b1;
                    ms_cnt_d = '0;
                end else begin
                    ms_cnt_d = ms_cnt_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q  <= '0;
            ms_cnt_q <= '0;
        end else begin
            presc_q  <= presc_d;
            ms_cnt_q <= ms_cnt_d;
        end
    end

endmodule

// File: rtl/key_debounce_scheduler.sv
// rtl/key_debounce_scheduler.sv - N-key debouncer sharing one timer, round-robin grant, valid/ready key events
// Optional feature macro: RELEASE_EVT_EN (confirmed releases also emit events).
module key_debounce_scheduler
    import key_debounce_scheduler_pkg::*;
#(
    parameter int N_KEYS = DEF_N_KEYS,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int T1MS   = DEF_T1MS,
    parameter int DEB_MS = DEF_DEB_MS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_State,
    output logic              Busy,
    key_debounce_scheduler_if.master evt
);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_KEYS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_KEYS - 1);
`ifdef RELEASE_EVT_EN
    localparam bit REL_EVT = 1'b1;
`else
    localparam bit REL_EVT = 1'b0;
`endif

    logic [N_KEYS-1:0] sync1_q, sync2_q, lvl_prev_q;
    logic [N_KEYS-1:0] lvl, owned, pending;
    logic [N_KEYS-1:0] ks_q, ks_d;

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_q, rr_d, rr_next;
    logic              evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0]  evt_key_q, evt_key_d;
    logic              evt_press_q, evt_press_d;

    logic [2*N_KEYS-1:0] rot2;
    logic [IDX_W-1:0]    off;
    logic [IDX_W:0]      sum;
    logic                found;
    logic [IDX_W-1:0]    pick;

    logic grant_lvl, grant_chg;
    logic tmr_clr, tmr_en, tmr_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            lvl_prev_q <= '0;
        end else begin
            sync1_q    <= Key_In;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl;
        end
    end

    assign lvl       = ~sync2_q;
    assign grant_lvl = lvl[grant_q];
    assign grant_chg = lvl[grant_q] ^ lvl_prev_q[grant_q];

    // The key holding the timer is never pending; every other differing key is.
    assign owned   = (state_q != ST_IDLE) ? (N_KEYS'(1) << grant_q) : '0;
    assign pending = (lvl ^ ks_q) & ~owned;

    // Rotate so bit 0 is the rr pointer, then take the lowest set bit.
    always_comb begin
        rot2  = {pending, pending} >> rr_q;
        found = 1'b0;
        off   = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (rot2[i]) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        pick = sum[IDX_W-1:0];
    end

    assign rr_next = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    assign tmr_en  = (state_q == ST_TIME);
    assign tmr_clr = (state_q == ST_IDLE) || ((state_q == ST_TIME) && grant_chg);

    ms_window_timer #(
        .T1MS   (T1MS),
        .DEB_MS (DEB_MS)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        ks_d        = ks_q;
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_press_d = evt_press_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_TIME;
                end
            end
            ST_TIME: begin
                if (tmr_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (grant_lvl != ks_q[grant_q]) begin
                    ks_d[grant_q] = grant_lvl;
                    if (grant_lvl || REL_EVT) begin
                        evt_valid_d = 1'b1;
                        evt_key_d   = grant_q;
                        evt_press_d = grant_lvl;
                        state_d     = ST_EMIT;
                    end else begin
                        rr_d    = rr_next;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Level fell back before the window closed: a glitch, no event.
                    rr_d    = rr_next;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (evt.Evt_Ready) begin
                    evt_valid_d = 1'b0;
                    rr_d        = rr_next;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            ks_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_press_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            ks_q        <= ks_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_press_q <= evt_press_d;
        end
    end

    assign Key_State     = ks_q;
    assign Busy          = (state_q != ST_IDLE);
    assign evt.Evt_Valid = evt_valid_q;
    assign evt.Evt_Key   = evt_key_q;
`ifdef RELEASE_EVT_EN
    assign evt.Evt_Press = evt_press_q;
`else
    assign evt.Evt_Press = 1'b1;
`endif

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// tb/tb_key_debounce_scheduler.sv - directed table and sequence bench for key_debounce_scheduler (T1MS=9, DEB_MS=3)
module tb_key_debounce_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] Key_In;
    logic [3:0] Key_State;
    logic       Busy;

    int passed = 0;
    int total  = 0;

    key_debounce_scheduler_if #(.IDX_W(2)) evt ();

    key_debounce_scheduler #(
        .N_KEYS (4),
        .IDX_W  (2),
        .T1MS   (9),
        .DEB_MS (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Key_In    (Key_In),
        .Key_State (Key_State),
        .Busy      (Busy),
        .evt       (evt.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] key_in;
        int         edges;
        logic       exp_valid;
        int         exp_key;
        logic [3:0] exp_state;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        Key_In = 4'b1111;
        evt.Evt_Ready = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic wait_valid(input int max_edges, output int n);
        n = 0;
        while (!evt.Evt_Valid && n < max_edges) begin
            step();
            n++;
        end
    endtask

    task automatic accept();
        evt.Evt_Ready = 1'b1;
        step();
        evt.Evt_Ready = 1'b0;
    endtask

    int n;
    int bad;

    initial begin
        RST = 1'b1;
        Key_In = 4'b1111;
        evt.Evt_Ready = 1'b0;

        vecs[0] = '{4'b1101, 33, 1'b0, 0, 4'b0000, 1'b1};
        vecs[1] = '{4'b1101, 34, 1'b1, 1, 4'b0010, 1'b1};
        vecs[2] = '{4'b1110, 34, 1'b1, 0, 4'b0001, 1'b1};
        vecs[3] = '{4'b0111, 34, 1'b1, 3, 4'b1000, 1'b1};
        vecs[4] = '{4'b1011, 34, 1'b1, 2, 4'b0100, 1'b1};

        step();
        RST = 1'b0;
        chk("rst_valid", int'(evt.Evt_Valid), 0);
        chk("rst_key", int'(evt.Evt_Key), 0);
        chk("rst_state", int'(Key_State), 0);
        chk("rst_busy", int'(Busy), 0);
`ifdef RELEASE_EVT_EN
        chk("rst_press", int'(evt.Evt_Press), 0);
`endif

        // Single-key presses: latency 2 sync + 1 grant + 30 window + 1 check edges.
        foreach (vecs[i]) begin
            do_reset();
            Key_In = vecs[i].key_in;
            repeat (vecs[i].edges) step();
            chk($sformatf("v%0d_valid", i), int'(evt.Evt_Valid), int'(vecs[i].exp_valid));
            chk($sformatf("v%0d_key", i), int'(evt.Evt_Key), vecs[i].exp_key);
            chk($sformatf("v%0d_state", i), int'(Key_State), int'(vecs[i].exp_state));
            chk($sformatf("v%0d_busy", i), int'(Busy), int'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_press", i), int'(evt.Evt_Press), 1);
                accept();
                chk($sformatf("v%0d_drop", i), int'(evt.Evt_Valid), 0);
                chk($sformatf("v%0d_idle", i), int'(Busy), 0);
            end
        end

        // Short low pulse on key 2 is a glitch.
        do_reset();
        Key_In = 4'b1011;
        repeat (10) step();
        Key_In = 4'b1111;
        bad = 0;
        repeat (60) begin
            step();
            if (evt.Evt_Valid) bad++;
        end
        chk("glitch_noevt", bad, 0);
        chk("glitch_state", int'(Key_State), 0);
        chk("glitch_busy", int'(Busy), 0);

        // Key 0 bounces; window restarts on each level change.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            Key_In = 4'b1110;
            repeat (5) step();
            Key_In = 4'b1111;
            repeat (5) step();
        end
        chk("bounce_noevt_yet", int'(evt.Evt_Valid), 0);
        Key_In = 4'b1110;
        wait_valid(100, n);
        chk("bounce_latency", n, 34);
        chk("bounce_key", int'(evt.Evt_Key), 0);
        chk("bounce_press", int'(evt.Evt_Press), 1);
        accept();

        // Keys 0,1,3 together: round-robin order, backpressure holds the event.
        do_reset();
        Key_In = 4'b0100;
        wait_valid(100, n);
        chk("multi0_latency", n, 34);
        chk("multi0_key", int'(evt.Evt_Key), 0);
        bad = 0;
        repeat (50) begin
            step();
            if (!evt.Evt_Valid || evt.Evt_Key != 2'd0 || !evt.Evt_Press || !Busy || Key_State != 4'b0001) bad++;
        end
        chk("multi0_hold", bad, 0);
        accept();
        chk("multi0_drop", int'(evt.Evt_Valid), 0);
        wait_valid(100, n);
        chk("multi1_latency", n, 32);
        chk("multi1_key", int'(evt.Evt_Key), 1);
        accept();
        wait_valid(100, n);
        chk("multi3_latency", n, 32);
        chk("multi3_key", int'(evt.Evt_Key), 3);
        accept();
        chk("multi_state", int'(Key_State), 4'b1011);

        // Release key 1.
        Key_In = 4'b0110;
`ifdef RELEASE_EVT_EN
        wait_valid(100, n);
        chk("rel_latency", n, 34);
        chk("rel_key", int'(evt.Evt_Key), 1);
        chk("rel_press", int'(evt.Evt_Press), 0);
        chk("rel_state", int'(Key_State), 4'b1001);
        accept();
        chk("rel_busy", int'(Busy), 0);
`else
        bad = 0;
        repeat (40) begin
            step();
            if (evt.Evt_Valid) bad++;
        end
        chk("rel_noevt", bad, 0);
        chk("rel_state", int'(Key_State), 4'b1001);
        chk("rel_busy", int'(Busy), 0);
`endif

        // Reset mid-TIME, then reset while in EMIT.
        do_reset();
        Key_In = 4'b1011;
        repeat (15) step();
        chk("rst_time_busy_pre", int'(Busy), 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_time_busy", int'(Busy), 0);
        chk("rst_time_valid", int'(evt.Evt_Valid), 0);
        chk("rst_time_state", int'(Key_State), 0);
        wait_valid(100, n);
        chk("rst_time_refresh", n, 34);
        chk("rst_time_key", int'(evt.Evt_Key), 2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_emit_valid", int'(evt.Evt_Valid), 0);
        chk("rst_emit_key", int'(evt.Evt_Key), 0);
        chk("rst_emit_state", int'(Key_State), 0);
        chk("rst_emit_busy", int'(Busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
